// File: rtl/seg_dice_if.sv
// Presentation bus of the dice reader: the raw segment pattern being sampled
// and the valid/ready handshake that carries a decoded face to its consumer.
interface seg_dice_if;
    logic [6:0] seg_in;
    logic       sample_en;
    logic       valid_out;
    logic       ready_in;
    logic [2:0] value_out;

    // Reader side: observes the display and presents decoded faces.
    modport master (
        input  seg_in,
        input  sample_en,
        input  ready_in,
        output valid_out,
        output value_out
    );

    // Environment/consumer side: drives the display and accepts faces.
    modport slave (
        output seg_in,
        output sample_en,
        output ready_in,
        input  valid_out,
        input  value_out
    );
endinterface

// File: rtl/seg_dice_reader.sv
// Seven-segment dice reader: debounces the segment pattern, decodes faces 1..6,
// presents each newly accepted face over a valid/ready handshake and keeps
// per-face and illegal-pattern statistics.
module seg_dice_reader #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    seg_dice_if.master       bus,
    input  logic             clear_stats,
    output logic             err_out,
    output logic             overrun,
    input  logic [2:0]       face_sel,
    output logic [CNT_W-1:0] face_count,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [6:0]       SEG_BLANK  = 7'b0000001;
    localparam logic [3:0]       STABLE_MAX = 4'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        ST_WAIT = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Face number for a legal pattern, 0 for blank or illegal patterns.
    function automatic logic [2:0] decode_face(input logic [6:0] seg);
        logic [2:0] face;
        case (seg)
            7'b0000110: face = 3'd1;
            7'b1011011: face = 3'd2;
            7'b1001111: face = 3'd3;
            7'b1100110: face = 3'd4;
            7'b1101101: face = 3'd5;
            7'b1111101: face = 3'd6;
            default:    face = 3'd0;
        endcase
        return face;
    endfunction

    // Saturating increment shared by all statistics counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    logic [6:0]       last_sample_r;
    logic [6:0]       last_sample_n_s;
    logic [3:0]       stab_cnt_r;
    logic [3:0]       stab_cnt_n_s;
    logic [6:0]       last_acc_r;
    logic             accept_s;
    logic [2:0]       face_s;
    logic             legal_acc_s;
    logic             blank_acc_s;
    logic             illegal_acc_s;
    state_t           state_r;
    state_t           state_n_s;
    logic [2:0]       value_r;
    logic [2:0]       value_n_s;
    logic             ovr_set_s;
    logic             err_r;
    logic             overrun_r;
    logic [CNT_W-1:0] face_cnt_r [1:6];
    logic [CNT_W-1:0] err_cnt_r;
    logic [CNT_W-1:0] face_count_s;

    // Next value of the debounce sampler; disabled edges leave it untouched.
    always_comb begin
        last_sample_n_s = last_sample_r;
        stab_cnt_n_s    = stab_cnt_r;
        if (bus.sample_en) begin
            if (bus.seg_in == last_sample_r) begin
                if (stab_cnt_r != STABLE_MAX) begin
                    stab_cnt_n_s = stab_cnt_r + 4'd1;
                end else begin
                    stab_cnt_n_s = stab_cnt_r;
                end
            end else begin
                stab_cnt_n_s    = 4'd1;
                last_sample_n_s = bus.seg_in;
            end
        end else begin
            stab_cnt_n_s    = stab_cnt_r;
            last_sample_n_s = last_sample_r;
        end
    end

    // Accept fires only on the edge where stability is first reached, and only
    // for a pattern different from the previously accepted one.
    always_comb begin
        face_s        = decode_face(bus.seg_in);
        accept_s      = bus.sample_en && (stab_cnt_n_s == STABLE_MAX) &&
                        (stab_cnt_r != STABLE_MAX) && (bus.seg_in != last_acc_r);
        blank_acc_s   = accept_s && (bus.seg_in == SEG_BLANK);
        legal_acc_s   = accept_s && (face_s != 3'd0);
        illegal_acc_s = accept_s && (face_s == 3'd0) && (bus.seg_in != SEG_BLANK);
    end

    // Debounce state and last-accepted pattern (blank also separates repeats).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_sample_r <= 7'b0000000;
            stab_cnt_r    <= 4'd0;
            last_acc_r    <= SEG_BLANK;
        end else begin
            last_sample_r <= last_sample_n_s;
            stab_cnt_r    <= stab_cnt_n_s;
            if (accept_s) begin
                last_acc_r <= bus.seg_in;
            end
        end
    end

    // Handshake FSM: a new face replaces the presented one only when the
    // consumer takes the old one on the same edge, otherwise it is dropped.
    always_comb begin
        state_n_s = state_r;
        value_n_s = value_r;
        ovr_set_s = 1'b0;
        case (state_r)
            ST_WAIT: begin
                if (legal_acc_s) begin
                    state_n_s = ST_HOLD;
                    value_n_s = face_s;
                end else begin
                    state_n_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (legal_acc_s && bus.ready_in) begin
                    value_n_s = face_s;
                end else if (legal_acc_s) begin
                    ovr_set_s = 1'b1;
                end else if (bus.ready_in) begin
                    state_n_s = ST_WAIT;
                end else begin
                    state_n_s = ST_HOLD;
                end
            end
            default: begin
                state_n_s = ST_WAIT;
            end
        endcase
    end

    // FSM state, presented value and the one-cycle error pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_WAIT;
            value_r <= 3'd0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_n_s;
            value_r <= value_n_s;
            err_r   <= illegal_acc_s;
        end
    end

    // Statistics and sticky overrun; a clear wins over any same-edge update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i <= 6; i++) begin
                face_cnt_r[i] <= '0;
            end
            err_cnt_r <= '0;
            overrun_r <= 1'b0;
        end else if (clear_stats) begin
            for (int i = 1; i <= 6; i++) begin
                face_cnt_r[i] <= '0;
            end
            err_cnt_r <= '0;
            overrun_r <= 1'b0;
        end else begin
            for (int i = 1; i <= 6; i++) begin
                if (legal_acc_s && (face_s == 3'(i))) begin
                    face_cnt_r[i] <= sat_inc(face_cnt_r[i]);
                end
            end
            if (illegal_acc_s) begin
                err_cnt_r <= sat_inc(err_cnt_r);
            end
            if (ovr_set_s) begin
                overrun_r <= 1'b1;
            end
        end
    end

    // Selected face counter; selections outside 1..6 read as zero.
    always_comb begin
        face_count_s = '0;
        case (face_sel)
            3'd1:    face_count_s = face_cnt_r[1];
            3'd2:    face_count_s = face_cnt_r[2];
            3'd3:    face_count_s = face_cnt_r[3];
            3'd4:    face_count_s = face_cnt_r[4];
            3'd5:    face_count_s = face_cnt_r[5];
            3'd6:    face_count_s = face_cnt_r[6];
            default: face_count_s = '0;
        endcase
    end

    assign bus.valid_out = (state_r == ST_HOLD);
    assign bus.value_out = value_r;
    assign err_out       = err_r;
    assign overrun       = overrun_r;
    assign err_count     = err_cnt_r;
    assign face_count    = face_count_s;

endmodule

// File: doc/seg_dice_reader.md
SEG_DICE_READER -- requirements
Module: seg_dice_reader

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4 (legal 2..15): consecutive identical enabled samples required to accept a pattern.
REQ-002 SHALL have parameter CNT_W, default 16: width of every statistics counter.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port seg_in  input  7  segment pattern under observation, bit 6 = segment g … bit 0 = segment a, active-high.
REQ-006 SHALL have port sample_en  input  1  sampling strobe; seg_in is sampled only on edges where it is 1.
REQ-007 SHALL have port clear_stats  input  1  synchronous clear of all statistics counters.
REQ-008 SHALL have port valid_out  output  1  a decoded face is presented.
REQ-009 SHALL have port ready_in  input  1  consumer accepts the face on an edge where valid_out=1 and ready_in=1.
REQ-010 SHALL have port value_out  output  3  decoded face 1..6.
REQ-011 SHALL have port err_out  output  1  one-cycle pulse when an illegal pattern is accepted.
REQ-012 SHALL have port overrun  output  1  sticky flag: an accepted face was dropped.
REQ-013 SHALL have port face_sel  input  3  face 1..6 whose count drives face_count.
REQ-014 SHALL have port face_count  output  CNT_W  count of accepted faces matching face_sel; 0 for face_sel 0 or 7.
REQ-015 SHALL have port err_count  output  CNT_W  count of accepted illegal patterns.

Function
REQ-016 SHALL decode the legal patterns 0000110=1, 1011011=2, 1001111=3, 1100110=4, 1101101=5, 1111101=6; pattern 0000001 is BLANK; every other pattern is ILLEGAL.
REQ-017 SHALL keep a last-sample register and a stability counter; on an enabled edge, a sample equal to the last sample increments the counter (saturating at STABLE_CYCLES), otherwise the counter loads 1 and the last sample loads seg_in.
REQ-018 SHALL hold the last sample and stability counter unchanged on edges with sample_en=0.
REQ-019 SHALL accept a pattern on the enabled edge where the counter reaches STABLE_CYCLES and the pattern differs from the last-accepted register; the accept loads the last-accepted register.
REQ-020 SHALL treat an accepted BLANK as a separator: it loads the last-accepted register, produces no output, error or count, so a repeated face after a blank is accepted again.
REQ-021 SHALL, on an accepted legal face, increment that face's counter and, in state WAIT, load value_out and move to state HOLD, raising valid_out on the same edge.
REQ-022 SHALL, on an accepted ILLEGAL pattern, pulse err_out for exactly one cycle and increment err_count, with no change to valid_out or value_out.
REQ-023 SHALL implement two states: WAIT (valid_out=0) and HOLD (valid_out=1, value_out stable); HOLD returns to WAIT on the edge where ready_in=1.
REQ-024 SHALL, when a legal face is accepted while in HOLD without a completing handshake on the same edge, keep the presented value, count the face, and set overrun.
REQ-025 SHALL, when the handshake completes on the same edge as a new legal accept, present the new face and stay in HOLD, without setting overrun.
REQ-026 SHALL saturate every counter at 2^CNT_W-1.
REQ-027 SHALL, when clear_stats=1, zero all counters and overrun on that edge, discarding any same-edge increment; the handshake path is unaffected.
REQ-028 SHALL make latency from the first enabled sample of a new stable pattern to valid_out=1 equal to STABLE_CYCLES enabled edges.

Reset
REQ-029 SHALL, while reset=1, force state WAIT, valid_out=0, value_out=0, err_out=0, overrun=0, all counters 0, stability counter 0, last sample 0000000, last-accepted BLANK.
REQ-030 SHALL, on reset asserted mid-HOLD, drop the pending face; the first post-reset accept is treated as new.

Verification
REQ-031 SHALL verify: pattern 1101101 held, sample_en=1, ready_in=0 -> valid_out=1, value_out=5 after 4th edge; face_sel=5 gives face_count=1.
REQ-032 SHALL verify: 1011011 for 3 edges, then 1001111 for 4 edges -> no output for 2, value_out=3, face 2 count 0.
REQ-033 SHALL verify: 0000110, blank 0000001, 0000110, each held 4 edges, ready_in=1 -> two handshakes of value 1, face 1 count 2.
REQ-034 SHALL verify: 1111111 held 4 edges -> single err_out pulse, err_count=1, valid_out stays 0.
REQ-035 SHALL verify: face 4 held in HOLD with ready_in=0, then face 6 accepted -> value_out stays 4, overrun=1, face 6 count 1; clear_stats -> counts and overrun 0.
REQ-036 SHALL verify: sample_en toggled 1,0,1,0 with constant 1100110 -> valid_out rises only on the 4th enabled edge; reset pulse in HOLD -> valid_out=0 immediately.
